// File: rtl/memshare_bank_issue_ctrl_if.sv
// Batch and column-bank handshake bundle for one shared-bank requestor group.
// The master drives batches and bank_ready; the slave issues to the bank.
interface memshare_bank_issue_ctrl_if #(
  parameter int GRP_SIZE = 4,
  parameter int BITWIDTH = 3,
  parameter int CNT_W    = 3
);
  logic                         batch_valid;
  logic                         batch_ready;
  logic [GRP_SIZE-1:0]          rqst_valid;
  logic [GRP_SIZE*BITWIDTH-1:0] rqst_in;
  logic                         bank_rd_en;
  logic [BITWIDTH-1:0]          bank_addr;
  logic [1:0]                   bank_rqst_id;
  logic                         bank_ready;
  logic [CNT_W-1:0]             pend_cnt;
  logic                         stall;
  logic                         batch_done;

  modport master (
    output batch_valid, rqst_valid, rqst_in, bank_ready,
    input  batch_ready, bank_rd_en, bank_addr, bank_rqst_id,
    input  pend_cnt, stall, batch_done
  );

  modport slave (
    input  batch_valid, rqst_valid, rqst_in, bank_ready,
    output batch_ready, bank_rd_en, bank_addr, bank_rqst_id,
    output pend_cnt, stall, batch_done
  );
endinterface

// File: rtl/memshare_bank_issue_ctrl.sv
// Compacts a batch of valid row requests into a queue and issues
// them one per accepted cycle to a shared column bank.
module memshare_bank_issue_ctrl #(
  parameter int GRP_SIZE = 4,
  parameter int BITWIDTH = 3,
  parameter int CNT_W    = 3
) (
  input logic sys_clk,
  input logic rstn,
  memshare_bank_issue_ctrl_if.slave bus
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] ISSUE = 1'b1;

  typedef logic [GRP_SIZE-1:0][BITWIDTH-1:0] slot_a_t;
  typedef logic [GRP_SIZE-1:0][1:0]          slot_i_t;

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  slot_a_t          addr_q, addr_d;
  slot_i_t          id_q, id_d;
  logic             done_q, done_d;

  slot_a_t          cmp_addr;
  slot_i_t          cmp_id;
  logic [CNT_W-1:0] cmp_n;

  logic rd_en;
  logic ready;
  logic accept;
  logic issue;

  // Handshake qualifiers; ready opens on the last issuing cycle.
  always_comb begin
    rd_en  = (cnt_q != '0);
    ready  = (state_q == IDLE) |
             ((state_q == ISSUE) &
              (cnt_q == CNT_W'(1)) & bus.bank_ready);
    accept = bus.batch_valid & ready;
    issue  = rd_en & bus.bank_ready;
  end

  // Pack valid requests into ascending slots; unused slots read 0.
  always_comb begin
    int c;
    cmp_addr = '0;
    cmp_id   = '0;
    cmp_n    = '0;
    c        = 0;
    for (int k = 0; k < GRP_SIZE; k++) begin
      cmp_n = cmp_n + CNT_W'(bus.rqst_valid[k]);
    end
    for (int j = 0; j < GRP_SIZE; j++) begin
      c = 0;
      for (int k = 0; k < GRP_SIZE; k++) begin
        if (bus.rqst_valid[k]) begin
          if (c == j) begin
            cmp_addr[j] = bus.rqst_in[k*BITWIDTH +: BITWIDTH];
            cmp_id[j]   = 2'(k);
          end
          c = c + 1;
        end
      end
    end
  end

  // Next state: shift on issue, then a new batch overrides the queue.
  always_comb begin
    addr_d = addr_q;
    id_d   = id_q;
    cnt_d  = cnt_q;
    done_d = 1'b0;
    if (issue) begin
      for (int j = 0; j < GRP_SIZE - 1; j++) begin
        addr_d[j] = addr_q[j+1];
        id_d[j]   = id_q[j+1];
      end
      addr_d[GRP_SIZE-1] = '0;
      id_d[GRP_SIZE-1]   = '0;
      cnt_d              = cnt_q - CNT_W'(1);
      done_d             = (cnt_q == CNT_W'(1));
    end
    if (accept) begin
      addr_d = cmp_addr;
      id_d   = cmp_id;
      cnt_d  = cmp_n;
      if (cmp_n == '0) begin
        done_d = 1'b1;
      end
    end
    state_d = (cnt_d != '0) ? ISSUE : IDLE;
  end

  // State registers with asynchronous clear.
  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      id_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      id_q    <= id_d;
      done_q  <= done_d;
    end
  end

  // Outputs: head slot and counters come straight from registers.
  always_comb begin
    bus.batch_ready  = ready;
    bus.stall        = bus.batch_valid & ~ready;
    bus.bank_rd_en   = rd_en;
    bus.bank_addr    = addr_q[0];
    bus.bank_rqst_id = id_q[0];
    bus.pend_cnt     = cnt_q;
    bus.batch_done   = done_q;
  end

endmodule

// File: tb/tb_memshare_bank_issue_ctrl.sv
// Directed bench for memshare_bank_issue_ctrl with a queue-based
// reference model checked every cycle plus literal spot checks.
module tb_memshare_bank_issue_ctrl;

  localparam int G  = 4;
  localparam int BW = 3;
  localparam int CW = 3;

  logic clk;
  logic rstn;

  memshare_bank_issue_ctrl_if #(.GRP_SIZE(G), .BITWIDTH(BW), .CNT_W(CW)) bus();

  memshare_bank_issue_ctrl #(.GRP_SIZE(G), .BITWIDTH(BW), .CNT_W(CW)) dut (
    .sys_clk(clk),
    .rstn(rstn),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [BW-1:0] addr;
    logic [1:0]    id;
  } req_t;

  req_t m_q[$];
  logic m_done;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: a FIFO of pending requests, applied per edge.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_q.delete();
      m_done = 1'b0;
    end else begin
      bit rdy;
      bit dn;
      rdy = (m_q.size() == 0) || (m_q.size() == 1 && bus.bank_ready);
      dn  = 1'b0;
      if (m_q.size() != 0 && bus.bank_ready) begin
        if (m_q.size() == 1) dn = 1'b1;
        void'(m_q.pop_front());
      end
      if (bus.batch_valid && rdy) begin
        if (bus.rqst_valid == '0) dn = 1'b1;
        for (int k = 0; k < G; k++) begin
          if (bus.rqst_valid[k]) begin
            req_t r;
            r.addr = bus.rqst_in[k*BW +: BW];
            r.id   = 2'(k);
            m_q.push_back(r);
          end
        end
      end
      m_done = dn;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    int n;
    logic [BW-1:0] ea;
    logic [1:0]    ei;
    logic          er;
    n  = m_q.size();
    ea = (n != 0) ? m_q[0].addr : '0;
    ei = (n != 0) ? m_q[0].id : '0;
    er = (n == 0) || (n == 1 && bus.bank_ready);
    chk("m_pend_cnt", 32'(bus.pend_cnt), 32'(n));
    chk("m_rd_en", 32'(bus.bank_rd_en), 32'(n != 0));
    chk("m_addr", 32'(bus.bank_addr), 32'(ea));
    chk("m_id", 32'(bus.bank_rqst_id), 32'(ei));
    chk("m_ready", 32'(bus.batch_ready), 32'(er));
    chk("m_stall", 32'(bus.stall), 32'(bus.batch_valid & ~er));
    chk("m_done", 32'(bus.batch_done), 32'(m_done));
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic head(input string nm, input int a, input int id,
                      input int pc);
    chk({nm, "_addr"}, 32'(bus.bank_addr), 32'(a));
    chk({nm, "_id"}, 32'(bus.bank_rqst_id), 32'(id));
    chk({nm, "_pend"}, 32'(bus.pend_cnt), 32'(pc));
    chk({nm, "_rd_en"}, 32'(bus.bank_rd_en), 32'd1);
  endtask

  initial begin
    rstn            = 1'b0;
    bus.batch_valid = 1'b0;
    bus.rqst_valid  = '0;
    bus.rqst_in     = '0;
    bus.bank_ready  = 1'b1;
    #1;
    chk("rst_pend", 32'(bus.pend_cnt), 32'd0);
    chk("rst_rd_en", 32'(bus.bank_rd_en), 32'd0);
    chk("rst_ready", 32'(bus.batch_ready), 32'd1);
    chk("rst_done", 32'(bus.batch_done), 32'd0);
    chk("rst_addr", 32'(bus.bank_addr), 32'd0);
    tick();
    tick();
    rstn = 1'b1;
    tick();

    // Full batch 5,2,7,1.
    bus.batch_valid = 1'b1;
    bus.rqst_valid  = 4'b1111;
    bus.rqst_in     = {3'd1, 3'd7, 3'd2, 3'd5};
    tick();
    bus.batch_valid = 1'b0;
    head("full0", 5, 0, 4);
    tick();
    head("full1", 2, 1, 3);
    tick();
    head("full2", 7, 2, 2);
    tick();
    head("full3", 1, 3, 1);
    tick();
    chk("full_done", 32'(bus.batch_done), 32'd1);
    chk("full_pend", 32'(bus.pend_cnt), 32'd0);
    chk("full_rd_en", 32'(bus.bank_rd_en), 32'd0);
    tick();
    chk("full_done_off", 32'(bus.batch_done), 32'd0);

    // Sparse batch 4'b1010.
    bus.batch_valid = 1'b1;
    bus.rqst_valid  = 4'b1010;
    bus.rqst_in     = {3'd3, 3'd0, 3'd6, 3'd0};
    tick();
    bus.batch_valid = 1'b0;
    head("sparse0", 6, 1, 2);
    tick();
    head("sparse1", 3, 3, 1);
    tick();
    chk("sparse_done", 32'(bus.batch_done), 32'd1);
    tick();

    // Back-pressure with a rejected second batch.
    bus.bank_ready  = 1'b0;
    bus.batch_valid = 1'b1;
    bus.rqst_valid  = 4'b0011;
    bus.rqst_in     = {3'd0, 3'd0, 3'd4, 3'd4};
    tick();
    bus.rqst_valid  = 4'b0100;
    bus.rqst_in     = {3'd0, 3'd5, 3'd0, 3'd0};
    head("bp0", 4, 0, 2);
    chk("bp_stall", 32'(bus.stall), 32'd1);
    chk("bp_ready", 32'(bus.batch_ready), 32'd0);
    tick();
    head("bp1", 4, 0, 2);
    tick();
    head("bp2", 4, 0, 2);
    bus.batch_valid = 1'b0;
    bus.bank_ready  = 1'b1;
    tick();
    head("bp3", 4, 1, 1);
    tick();
    chk("bp_done", 32'(bus.batch_done), 32'd1);
    tick();

    // Back-to-back batches without a bubble.
    bus.batch_valid = 1'b1;
    bus.rqst_valid  = 4'b0011;
    bus.rqst_in     = {3'd0, 3'd0, 3'd2, 3'd1};
    tick();
    bus.rqst_valid  = 4'b0001;
    bus.rqst_in     = {3'd0, 3'd0, 3'd0, 3'd3};
    head("b2b0", 1, 0, 2);
    chk("b2b_stall", 32'(bus.stall), 32'd1);
    tick();
    head("b2b1", 2, 1, 1);
    chk("b2b_ready", 32'(bus.batch_ready), 32'd1);
    tick();
    bus.batch_valid = 1'b0;
    head("b2b2", 3, 0, 1);
    chk("b2b_done1", 32'(bus.batch_done), 32'd1);
    tick();
    chk("b2b_done2", 32'(bus.batch_done), 32'd1);
    chk("b2b_pend", 32'(bus.pend_cnt), 32'd0);
    tick();

    // Empty batch.
    bus.batch_valid = 1'b1;
    bus.rqst_valid  = 4'b0000;
    bus.rqst_in     = {3'd7, 3'd7, 3'd7, 3'd7};
    tick();
    bus.batch_valid = 1'b0;
    chk("empty_done", 32'(bus.batch_done), 32'd1);
    chk("empty_rd_en", 32'(bus.bank_rd_en), 32'd0);
    chk("empty_ready", 32'(bus.batch_ready), 32'd1);
    tick();
    chk("empty_done_off", 32'(bus.batch_done), 32'd0);

    // Asynchronous reset mid-batch.
    bus.bank_ready  = 1'b0;
    bus.batch_valid = 1'b1;
    bus.rqst_valid  = 4'b0111;
    bus.rqst_in     = {3'd0, 3'd3, 3'd2, 3'd1};
    tick();
    bus.batch_valid = 1'b0;
    head("ar0", 1, 0, 3);
    #1;
    rstn = 1'b0;
    #1;
    chk("ar_pend", 32'(bus.pend_cnt), 32'd0);
    chk("ar_rd_en", 32'(bus.bank_rd_en), 32'd0);
    chk("ar_addr", 32'(bus.bank_addr), 32'd0);
    tick();
    bus.bank_ready = 1'b1;
    tick();
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("ar_no_done", 32'(bus.batch_done), 32'd0);
      chk("ar_idle", 32'(bus.bank_rd_en), 32'd0);
    end

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
